// File: rtl/if_id_buffer.sv
// Elastic IF/ID boundary: a small circular buffer of {PC, instruction} between fetch
// and decode, with freeze back-pressure to fetch and a flush on a taken branch.
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          ifPC,
  input  logic [WIDTH-1:0]          ifInstruction,
  input  logic                      brTaken,
  input  logic                      idStall,
  output logic                      freeze,
  output logic                      idValid,
  output logic [WIDTH-1:0]          idPC,
  output logic [WIDTH-1:0]          idInstruction,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] pc_mem  [DEPTH];
  logic [WIDTH-1:0] ins_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  always_comb begin
    idValid = (count != '0);
    freeze  = (count == FULL_CNT) && !brTaken;
    push    = !freeze && !brTaken;
    pop     = idValid && !idStall && !brTaken;
  end

  // Entries are only ever read when counted valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= ifPC;
      ins_mem[wr_ptr] <= ifInstruction;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (brTaken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    idPC          = idValid ? pc_mem[rd_ptr]  : '0;
    idInstruction = idValid ? ins_mem[rd_ptr] : '0;
    occupancy     = count;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Elastic IF-to-ID boundary that receives the fetch stage's PC/instruction stream, queues it in a small circular buffer, and hands words to decode under a stall handshake. It drives the fetch stage's `freeze` when full and discards wrong-path words on `brTaken`. It sits between the instruction-fetch stage and the decode stage and replaces a plain IF/ID pipeline register.

## Interface
- `DEPTH`, 2: entry count; power of two, ≥2.
- `WIDTH`, 32: PC and instruction width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `ifPC`  in  WIDTH  PC currently presented by the fetch stage.
- `ifInstruction`  in  WIDTH  instruction at `ifPC`.
- `brTaken`  in  1  branch resolved taken; the same signal is fed to the fetch stage.
- `idStall`  in  1  decode cannot accept the head word this cycle.
- `freeze`  out  1  to the fetch stage; high = hold PC, word not consumed.
- `idValid`  out  1  head word valid.
- `idPC`  out  WIDTH  head entry PC; 0 when `idValid`=0.
- `idInstruction`  out  WIDTH  head entry instruction; 0 when `idValid`=0.
- `occupancy`  out  log2(DEPTH)+1  number of stored entries.

## Operation
- Storage: DEPTH entries of {PC, instruction}; write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count 0..DEPTH.
- `freeze` = (count == DEPTH) AND NOT `brTaken`. This is combinational from the registered count and `brTaken` only; there is no path from `idStall`.
- push = NOT `freeze` AND NOT `brTaken`. On push, {`ifPC`, `ifInstruction`} is written at the write pointer, and the write pointer increments.
- pop = `idValid` AND NOT `idStall` AND NOT `brTaken`. On pop, the read pointer increments.
- count_next = count + push − pop. Push and pop may occur together at any count < DEPTH, leaving the count unchanged.
- At count == DEPTH, `freeze` is high, so there is no push. A pop still occurs if `idStall`=0. The word at the fetch port is retained by the fetch stage and captured on the next non-frozen edge.
- Flush (`brTaken`=1 at an edge):
  - All entries are invalidated: count, write pointer and read pointer all go to 0.
  - The word presented on the fetch port that cycle is wrong-path and is not written.
  - `freeze` is forced low, so the fetch stage loads the branch target on the same edge.
  - Flush overrides push, pop and `idStall`.
- `idValid` = (count ≠ 0). `idPC`/`idInstruction` read combinationally from the entry at the read pointer, and are gated to 0 when empty.
- `occupancy` = count.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - count and both pointers to 0;
  - `idValid`, `freeze` and `occupancy` to 0;
  - `idPC` and `idInstruction` to 0.
- Storage contents need not be cleared.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Release is synchronous to the next rising edge. The first push can occur at the first edge after release.
- Latency: a word pushed at edge N is visible on `idPC`/`idInstruction` with `idValid`=1 after edge N. There is no same-cycle bypass from the fetch port to decode.
- Throughput: one word per cycle sustained while `idStall`=0.
- `freeze` rises the cycle after the edge that makes count = DEPTH. It falls the cycle after the first pop from full, or immediately (combinationally) on `brTaken`.
- Ordering is strict FIFO. No word is duplicated or dropped except by flush or reset.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. Wrap is transparent to ordering.
- Flush and reset both empty the buffer. After a flush, the first new word appears one cycle after the next push edge.

## Test plan
- Streaming:
  - Stimulus: after reset, present PC 0x00, 0x04, 0x08, 0x0C on consecutive edges with `idStall`=0.
  - Response: `idValid` rises one cycle after the first edge; `idPC` shows 0x00, 0x04, 0x08, 0x0C in order; `freeze` stays 0; `occupancy` stays 1.
- Fill to full:
  - Stimulus: `idStall`=1 and DEPTH=2; present 0x10, then 0x14.
  - Response: `occupancy` goes 1 then 2; `freeze`=1 from the cycle after the second edge; further PCs (0x18, held by fetch) are not written.
  - Stimulus: release `idStall`.
  - Response: pop order is 0x10, 0x14, then 0x18.
- Simultaneous push and pop:
  - Stimulus: count=1, `idStall`=0, new word present.
  - Response: `occupancy` remains 1; head advances by one entry per cycle.
- Flush while full:
  - Stimulus: count=2 and `freeze`=1, then `brTaken`=1 for one cycle with `ifPC`=0x20.
  - Response: `freeze` drops to 0 in the same cycle; after the edge `occupancy`=0, `idValid`=0, `idPC`=0; 0x20 is never output.
  - Stimulus: target word 0x40 arrives at the next edge.
  - Response: `idPC`=0x40 one cycle later.
- Async reset mid-stream:
  - Stimulus: with count=2, drive `rst` low between edges.
  - Response: `idValid`, `freeze` and `occupancy` go to 0 without a clock edge.
  - Stimulus: after release, present PC 0x00.
  - Response: 0x00 is accepted on the first edge.
- Wrap-around:
  - Stimulus: 5 pushes with alternating `idStall`.
  - Response: output sequence matches input sequence exactly across pointer wrap; `occupancy` never exceeds DEPTH.
